// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared encodings and types for the pipeline hazard controller.
package pipeline_hazard_ctrl_pkg;

   // ALU operand source selects
   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   // ResultSrcE value that marks a load in E
   localparam logic [1:0] RESULT_LOAD = 2'b01;

   // Data-memory handshake tracker
   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StWait = 2'd1,
      StErr  = 2'd2
   } mem_state_e;

endpackage

// File: rtl/forwarding_unit.sv
// Selects the ALU operand source for one E-stage source register.
module forwarding_unit
   import pipeline_hazard_ctrl_pkg::*;
(
   input  logic [4:0] rs,
   input  logic [4:0] rd_m,
   input  logic [4:0] rd_w,
   input  logic       reg_write_m,
   input  logic       reg_write_w,
   output logic [1:0] fwd
);

   // M has the younger value, so it wins over W; x0 is never forwarded
   always_comb begin
      fwd = FWD_RF;
      if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs)) begin
         fwd = FWD_MEM;
      end else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs)) begin
         fwd = FWD_WB;
      end
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard unit: operand forwarding, load-use stall, branch flush and a
// data-memory wait tracker with timeout.
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  Rs1D,
   input  logic [4:0]  Rs2D,
   input  logic [4:0]  Rs1E,
   input  logic [4:0]  Rs2E,
   input  logic [4:0]  RDE,
   input  logic [4:0]  RDM,
   input  logic [4:0]  RDW,
   input  logic        RegWriteM,
   input  logic        RegWriteW,
   input  logic [1:0]  ResultSrcE,
   input  logic        PCSrcE,
   input  logic        MemReqM,
   input  logic        DMemReady,
   output logic [1:0]  ForwardAE,
   output logic [1:0]  ForwardBE,
   output logic        StallF,
   output logic        StallD,
   output logic        StallE,
   output logic        StallM,
   output logic        FlushD,
   output logic        FlushE,
   output logic        FlushW,
   output logic        MemErr,
   output logic [15:0] StallCount
);

   // Last counter value seen in WAIT before the timeout fires
   localparam logic [7:0] WaitLast = 8'(TIMEOUT_CYCLES - 1);

   mem_state_e  state_q, state_d;
   logic [7:0]  wait_cnt_q, wait_cnt_d;
   logic [15:0] stall_cnt_q;
   logic        mem_stall;
   logic        lw_stall;
   logic [1:0]  fwd_a, fwd_b;

   forwarding_unit u_fwd_a (
      .rs          (Rs1E),
      .rd_m        (RDM),
      .rd_w        (RDW),
      .reg_write_m (RegWriteM),
      .reg_write_w (RegWriteW),
      .fwd         (fwd_a)
   );

   forwarding_unit u_fwd_b (
      .rs          (Rs2E),
      .rd_m        (RDM),
      .rd_w        (RDW),
      .reg_write_m (RegWriteM),
      .reg_write_w (RegWriteW),
      .fwd         (fwd_b)
   );

   assign lw_stall = (ResultSrcE == RESULT_LOAD) && (RDE != 5'd0) &&
                     ((RDE == Rs1D) || (RDE == Rs2D));

   // Memory FSM and wait counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   // Memory FSM next state; the stall is raised in the same cycle as the miss
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      mem_stall  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (MemReqM && !DMemReady) begin
               mem_stall  = 1'b1;
               state_d    = StWait;
               wait_cnt_d = '0;
            end
         end
         StWait: begin
            wait_cnt_d = wait_cnt_q + 8'd1;
            if (DMemReady) begin
               state_d = StIdle;
            end else begin
               mem_stall = 1'b1;
               if (wait_cnt_q == WaitLast) begin
                  state_d = StErr;
               end
            end
         end
         StErr: begin
            mem_stall = 1'b1;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Saturating count of cycles with the fetch stage held
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
      end else if (StallF && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_q <= stall_cnt_q + 16'd1;
      end
   end

   // Stall/flush decode; a memory stall freezes everything and defers flushes
   always_comb begin
      StallF = 1'b0;
      StallD = 1'b0;
      StallE = 1'b0;
      StallM = 1'b0;
      FlushD = 1'b0;
      FlushE = 1'b0;
      FlushW = 1'b0;
      if (rst_n) begin
         if (mem_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
         end else begin
            StallF = lw_stall;
            StallD = lw_stall;
            FlushD = PCSrcE;
            FlushE = lw_stall | PCSrcE;
         end
      end
   end

   assign ForwardAE  = rst_n ? fwd_a : FWD_RF;
   assign ForwardBE  = rst_n ? fwd_b : FWD_RF;
   assign MemErr     = (state_q == StErr);
   assign StallCount = stall_cnt_q;

endmodule
